// File: rtl/fft_r22sdf_twiddle_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_r22sdf_twiddle_mult_if                                                  |
// | Sample stream into and out of the R2^2 SDF twiddle rotator.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fft_r22sdf_twiddle_mult_if #(
  parameter int DW = 25
);
  logic                 valid_i;
  logic signed [DW-1:0] x_re_i;
  logic signed [DW-1:0] x_im_i;
  logic                 valid_o;
  logic                 sync_o;
  logic signed [DW-1:0] z_re_o;
  logic signed [DW-1:0] z_im_o;

  modport master (
    output valid_i, x_re_i, x_im_i,
    input  valid_o, sync_o, z_re_o, z_im_o
  );

  modport slave (
    input  valid_i, x_re_i, x_im_i,
    output valid_o, sync_o, z_re_o, z_im_o
  );
endinterface
`default_nettype wire

// File: rtl/fft_r22sdf_twiddle_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_r22sdf_twiddle_mult                                                     |
// | Rotates each valid sample by W_N^e (frame-position driven), 4-cycle pipe.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fft_r22sdf_twiddle_mult #(
  parameter int DW     = 25,
  parameter int TWW    = 25,
  parameter int N_LOG2 = 6
) (
  input  wire logic                clk_i,
  input  wire logic                rst_n,
  fft_r22sdf_twiddle_mult_if.slave bus
);
  localparam int  N     = 1 << N_LOG2;
  localparam int  PW    = DW + TWW;
  localparam int  SW    = DW + TWW + 1;
  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = (2.0 ** (TWW - 1)) - 1.0;

  localparam logic signed [SW:0] RND     = {{(SW - TWW + 2){1'b0}}, 1'b1, {(TWW - 2){1'b0}}};
  localparam logic signed [SW:0] SAT_HI  = {{(SW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [SW:0] SAT_LO  = {{(SW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};
  localparam logic signed [DW-1:0] OUT_HI = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0] OUT_LO = {1'b1, {(DW - 1){1'b0}}};

  function automatic int round_r(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

  function automatic logic signed [TWW-1:0] rom_cos(input int e);
    return TWW'(round_r(SCALE * $cos(2.0 * PI * real'(e) / real'(N))));
  endfunction

  function automatic logic signed [TWW-1:0] rom_nsin(input int e);
    return TWW'(round_r(-SCALE * $sin(2.0 * PI * real'(e) / real'(N))));
  endfunction

  // Round half up at the TWW-1 binary point, then clamp to the DW-bit range.
  function automatic logic signed [DW-1:0] rnd_sat(input logic signed [SW-1:0] v);
    logic signed [SW:0] sum;
    logic signed [SW:0] sh;
    sum = {v[SW-1], v} + RND;
    sh  = sum >>> (TWW - 1);
    if (sh > SAT_HI)      return OUT_HI;
    else if (sh < SAT_LO) return OUT_LO;
    else                  return sh[DW-1:0];
  endfunction

  logic signed [TWW-1:0] rom_c [N];
  logic signed [TWW-1:0] rom_d [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_rom
    localparam logic signed [TWW-1:0] C_E = rom_cos(gi);
    localparam logic signed [TWW-1:0] D_E = rom_nsin(gi);
    assign rom_c[gi] = C_E;
    assign rom_d[gi] = D_E;
  end

  // Frame position and twiddle exponent
  logic [N_LOG2-1:0] ctr_q, ctr_d;
  logic [1:0]        w_quad;
  logic [N_LOG2-3:0] w_n;
  logic [1:0]        w_m;
  logic [N_LOG2-1:0] w_e;

  always_comb begin
    w_quad = ctr_q[N_LOG2-1 -: 2];
    w_n    = ctr_q[N_LOG2-3:0];
    case (w_quad)
      2'd0:    w_m = 2'd0;
      2'd1:    w_m = 2'd2;
      2'd2:    w_m = 2'd1;
      default: w_m = 2'd3;
    endcase
    w_e   = {2'b00, w_n} * {{(N_LOG2 - 2){1'b0}}, w_m};
    ctr_d = bus.valid_i ? ctr_q + 1'b1 : ctr_q;
  end

  // Control delay line (reset) alongside the data path (no reset)
  logic v1_q, v2_q, v3_q;
  logic f1_q, f2_q, f3_q;
  logic b1_q, b2_q, b3_q;

  logic signed [DW-1:0]  xr1_q, xi1_q, xr2_q, xi2_q, xr3_q, xi3_q;
  logic signed [TWW-1:0] c1_q, d1_q;
  logic signed [PW-1:0]  p_ac_q, p_bd_q, p_bc_q, p_ad_q;
  logic signed [SW-1:0]  re3_q, im3_q;

  logic                 valid_q, valid_d;
  logic                 sync_q, sync_d;
  logic signed [DW-1:0] zr_q, zr_d;
  logic signed [DW-1:0] zi_q, zi_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ctr_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      f1_q  <= 1'b0;
      f2_q  <= 1'b0;
      f3_q  <= 1'b0;
    end else begin
      ctr_q <= ctr_d;
      v1_q  <= bus.valid_i;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      f1_q  <= bus.valid_i && (ctr_q == '0);
      f2_q  <= f1_q;
      f3_q  <= f2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    xr1_q  <= bus.x_re_i;
    xi1_q  <= bus.x_im_i;
    c1_q   <= rom_c[w_e];
    d1_q   <= rom_d[w_e];
    b1_q   <= (w_e == '0);

    p_ac_q <= PW'(xr1_q) * PW'(c1_q);
    p_bd_q <= PW'(xi1_q) * PW'(d1_q);
    p_bc_q <= PW'(xi1_q) * PW'(c1_q);
    p_ad_q <= PW'(xr1_q) * PW'(d1_q);
    xr2_q  <= xr1_q;
    xi2_q  <= xi1_q;
    b2_q   <= b1_q;

    re3_q  <= SW'(p_ac_q) - SW'(p_bd_q);
    im3_q  <= SW'(p_bc_q) + SW'(p_ad_q);
    xr3_q  <= xr2_q;
    xi3_q  <= xi2_q;
    b3_q   <= b2_q;
  end

  // e==0 passes x through untouched so the unit twiddle adds no scaling error.
  always_comb begin
    valid_d = v3_q;
    sync_d  = v3_q && f3_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    if (v3_q) begin
      zr_d = b3_q ? xr3_q : rnd_sat(re3_q);
      zi_d = b3_q ? xi3_q : rnd_sat(im3_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      zr_q    <= '0;
      zi_q    <= '0;
    end else begin
      valid_q <= valid_d;
      sync_q  <= sync_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.sync_o  = sync_q;
  assign bus.z_re_o  = zr_q;
  assign bus.z_im_o  = zi_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_r22sdf_twiddle_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_r22sdf_twiddle_mult                                                  |
// | Directed vectors plus a cycle-level reference model for N=16.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fft_r22sdf_twiddle_mult;
  localparam int  DW     = 25;
  localparam int  TWW    = 25;
  localparam int  N_LOG2 = 4;
  localparam int  N      = 16;
  localparam real PI     = 3.14159265358979323846;
  localparam real SCALE  = 16777215.0;
  localparam longint XMAX = 64'sd16777215;
  localparam longint XMIN = -64'sd16777216;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  fft_r22sdf_twiddle_mult_if #(.DW(DW)) bus ();

  fft_r22sdf_twiddle_mult #(.DW(DW), .TWW(TWW), .N_LOG2(N_LOG2)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  longint mc [N];
  longint md [N];
  int     m_ctr;
  bit     pv [4];
  bit     ps [4];
  longint pre [4];
  longint pim [4];
  longint held_re, held_im;

  int                 out_cnt;
  int                 sync_at [$];
  logic signed [63:0] cap_re [64];
  logic signed [63:0] cap_im [64];

  typedef struct {
    int     idx;
    longint xr;
    longint xi;
    longint er;
    longint ei;
    int     tol;
    string  nm;
  } vec_t;

  vec_t tbl [8];
  int   e0_idx [7] = '{0, 1, 2, 3, 4, 8, 12};

  function automatic longint rnd(input real v);
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    else          return -longint'($rtoi(0.5 - v));
  endfunction

  function automatic longint clamp(input longint v);
    if (v > XMAX) return XMAX;
    if (v < XMIN) return XMIN;
    return v;
  endfunction

  task automatic model_z(input longint a, input longint b, input int e,
                         output longint zr, output longint zi);
    longint re, im;
    longint half;
    half = longint'(1) << (TWW - 2);
    if (e == 0) begin
      zr = a;
      zi = b;
    end else begin
      re = a * mc[e] - b * md[e];
      im = b * mc[e] + a * md[e];
      zr = clamp((re + half) >>> (TWW - 1));
      zi = clamp((im + half) >>> (TWW - 1));
    end
  endtask

  function automatic longint rand_x();
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    return longint'(t);
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input logic signed [63:0] act, input longint exp,
                         input int tol);
    longint d;
    n_checks++;
    d = longint'(act) - exp;
    if ($isunknown(act) || d > tol || d < -tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d +/-%0d", nm, act, exp, tol);
    end
  endtask

  // One clock: drive inputs, advance the reference pipeline, compare every output.
  task automatic step(input bit rst, input bit v, input longint xr, input longint xi);
    int     q, n, mm, e;
    longint nr, ni;
    bus.valid_i = v;
    bus.x_re_i  = DW'(xr);
    bus.x_im_i  = DW'(xi);
    rst_n       = !rst;
    q  = m_ctr >> (N_LOG2 - 2);
    n  = m_ctr % (N / 4);
    mm = (q == 0) ? 0 : (q == 1) ? 2 : (q == 2) ? 1 : 3;
    e  = n * mm;
    model_z(xr, xi, e, nr, ni);
    @(posedge clk_i);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] = 1'b0;
        ps[i] = 1'b0;
      end
      m_ctr   = 0;
      held_re = 0;
      held_im = 0;
    end else begin
      for (int i = 3; i > 0; i--) begin
        pv[i]  = pv[i-1];
        ps[i]  = ps[i-1];
        pre[i] = pre[i-1];
        pim[i] = pim[i-1];
      end
      pv[0]  = v;
      ps[0]  = v && (m_ctr == 0);
      pre[0] = nr;
      pim[0] = ni;
      if (v) m_ctr = (m_ctr + 1) % N;
      if (pv[3]) begin
        held_re = pre[3];
        held_im = pim[3];
      end
    end
    chk("valid_o", {63'b0, bus.valid_o}, longint'(pv[3]));
    chk("sync_o", {63'b0, bus.sync_o}, longint'(pv[3] && ps[3]));
    chk("z_re_o", 64'($signed(bus.z_re_o)), held_re);
    chk("z_im_o", 64'($signed(bus.z_im_o)), held_im);
    if (bus.valid_o === 1'b1) begin
      if (out_cnt < 64) begin
        cap_re[out_cnt] = 64'($signed(bus.z_re_o));
        cap_im[out_cnt] = 64'($signed(bus.z_im_o));
      end
      if (bus.sync_o === 1'b1) sync_at.push_back(out_cnt);
      out_cnt++;
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.x_re_i  = '0;
    bus.x_im_i  = '0;
    m_ctr   = 0;
    out_cnt = 0;
    held_re = 0;
    held_im = 0;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      ps[i] = 1'b0;
      pre[i] = 0;
      pim[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      mc[i] = rnd(SCALE * $cos(2.0 * PI * real'(i) / real'(N)));
      md[i] = rnd(-SCALE * $sin(2.0 * PI * real'(i) / real'(N)));
    end

    tbl[0] = '{5,  1000, 0,    707,  -707,  1, "e2_idx5"};
    tbl[1] = '{9,  1000, 0,    924,  -383,  1, "e1_idx9"};
    tbl[2] = '{13, 1000, 0,    383,  -924,  1, "e3_idx13"};
    tbl[3] = '{15, 1000, 0,    -924, 383,   1, "e9_idx15"};
    tbl[4] = '{14, 1000, 0,    -707, -707,  1, "e6_idx14"};
    tbl[5] = '{6,  1000, -500, -500, -1000, 0, "e4_idx6"};
    tbl[6] = '{5,  XMAX, XMAX, XMAX, 0,     1, "sat_pos_idx5"};
    tbl[7] = '{5,  XMIN, XMIN, XMIN, 0,     1, "sat_neg_idx5"};

    // Reset state
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);

    // One full frame of (1000,0)
    out_cnt = 0;
    sync_at.delete();
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 1000, 0);
    repeat (4) step(1'b0, 1'b0, 0, 0);
    chk("frame_out_count", 64'(out_cnt), 16);
    chk("frame_sync_count", 64'(sync_at.size()), 1);
    chk("frame_sync_pos", (sync_at.size() > 0) ? 64'(sync_at[0]) : -64'sd1, 0);
    for (int k = 0; k < 7; k++) begin
      chk("unit_twiddle_re", cap_re[e0_idx[k]], 1000);
      chk("unit_twiddle_im", cap_im[e0_idx[k]], 0);
    end

    // Single non-zero sample placed at a chosen frame index
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 0, 0);
      out_cnt = 0;
      for (int i = 0; i <= tbl[k].idx; i++) begin
        if (i == tbl[k].idx) step(1'b0, 1'b1, tbl[k].xr, tbl[k].xi);
        else                 step(1'b0, 1'b1, 0, 0);
      end
      repeat (4) step(1'b0, 1'b0, 0, 0);
      chk_tol({tbl[k].nm, "_re"}, cap_re[tbl[k].idx], tbl[k].er, tbl[k].tol);
      chk_tol({tbl[k].nm, "_im"}, cap_im[tbl[k].idx], tbl[k].ei, tbl[k].tol);
    end

    // Gapped input: 32 samples, second sync on the 17th output
    step(1'b1, 1'b0, 0, 0);
    out_cnt = 0;
    sync_at.delete();
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b1, rand_x(), rand_x());
    end
    repeat (4) step(1'b0, 1'b0, 0, 0);
    chk("gap_out_count", 64'(out_cnt), 32);
    chk("gap_sync_count", 64'(sync_at.size()), 2);
    chk("gap_sync2_pos", (sync_at.size() > 1) ? 64'(sync_at[1]) : -64'sd1, 16);

    // Reset mid-frame at index 7 with samples in flight
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1000, 300);
    out_cnt = 0;
    sync_at.delete();
    step(1'b1, 1'b0, 0, 0);
    chk("midrst_valid", {63'b0, bus.valid_o}, 0);
    chk("midrst_z_re", 64'($signed(bus.z_re_o)), 0);
    step(1'b0, 1'b1, 1000, 0);
    repeat (4) step(1'b0, 1'b0, 0, 0);
    chk("midrst_out_count", 64'(out_cnt), 1);
    chk("midrst_sync_first", (sync_at.size() > 0) ? 64'(sync_at[0]) : -64'sd1, 0);

    // Random frames, full-range data with occasional extremes
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 10000; i++) begin
      longint a, b;
      a = rand_x();
      b = rand_x();
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) != 0) ? XMAX : XMIN;
      if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) != 0) ? XMAX : XMIN;
      if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b1, a, b);
    end
    repeat (4) step(1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
